// File: rtl/mcp3_ram512x080.sv
// 512x80 simple dual-port RAM: one write port, one read port with a
// registered, read-enable-gated output (q holds until the next read).
module mcp3_ram512x080 (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [8:0]  wr_addr,
  input  logic [79:0] wr_data,
  input  logic        rd_en,
  input  logic [8:0]  rd_addr,
  output logic [79:0] rd_data
);

  logic [79:0] mem [512];
  logic [79:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mcp3_fifo512x080_ctl.sv
// 512-deep, 80-bit FIFO controller: RAM storage plus a two-entry output
// stage that hides the RAM read latency and gives full throughput.
module mcp3_fifo512x080_ctl #(
  parameter int AFULL_THRESH = 496
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [79:0] i_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [79:0] o_data,
  output logic [9:0]  count,
  output logic        almost_full
);

  localparam int DEPTH = 512;
  localparam int WIDTH = 80;
  localparam int PTR_W = 9;
  localparam int CNT_W = 10;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] ram_cnt_reg;
  logic [CNT_W-1:0] ram_cnt_next;
  logic             inflight_reg;
  logic [WIDTH-1:0] st_reg [2];
  logic [WIDTH-1:0] st_next [2];
  logic [1:0]       st_cnt_reg;
  logic [1:0]       st_cnt_next;
  logic             i_ready_reg;
  logic             almost_full_reg;
  logic [WIDTH-1:0] ram_q;

  logic push;
  logic pop;
  logic rd_issue;

  // The head is either a settled stage entry or the RAM word that has just
  // arrived from last cycle's read; both are pure register outputs.
  assign o_valid = (st_cnt_reg != 2'd0) || inflight_reg;
  assign o_data  = (st_cnt_reg != 2'd0) ? st_reg[0] : ram_q;

  assign push = i_valid && i_ready_reg && !reset;
  assign pop  = o_valid && o_ready;

  // ram_cnt_reg only counts words written on earlier edges, so a read can
  // never target the slot being written in the same cycle.
  assign st_cnt_next = st_cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};
  assign rd_issue    = !reset && (ram_cnt_reg != '0) && (st_cnt_next < 2'd2);

  assign count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign ram_cnt_next = ram_cnt_reg + CNT_W'(push) - CNT_W'(rd_issue);

  always_comb begin
    st_next[0] = st_reg[0];
    st_next[1] = st_reg[1];
    if (pop) begin
      if (st_cnt_reg == 2'd2) begin
        st_next[0] = st_reg[1];
      end else if (st_cnt_reg == 2'd1 && inflight_reg) begin
        st_next[0] = ram_q;
      end
    end else if (inflight_reg) begin
      if (st_cnt_reg == 2'd0) begin
        st_next[0] = ram_q;
      end else begin
        st_next[1] = ram_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    st_reg[0] <= st_next[0];
    st_reg[1] <= st_next[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      ram_cnt_reg     <= '0;
      inflight_reg    <= 1'b0;
      st_cnt_reg      <= 2'd0;
      i_ready_reg     <= 1'b0;
      almost_full_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg       <= count_next;
      ram_cnt_reg     <= ram_cnt_next;
      inflight_reg    <= rd_issue;
      st_cnt_reg      <= st_cnt_next;
      i_ready_reg     <= (int'(count_next) < DEPTH);
      almost_full_reg <= (int'(count_next) >= AFULL_THRESH);
    end
  end

  assign i_ready     = i_ready_reg;
  assign count       = count_reg;
  assign almost_full = almost_full_reg;

  mcp3_ram512x080 u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (i_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_q)
  );

endmodule

// File: doc/mcp3_fifo512x080_ctl.md
MCP3_FIFO512X080_CTL -- requirements
Module: mcp3_fifo512x080_ctl

Interface
REQ-001 SHALL have parameter: AFULL_THRESH, default 496, almost_full asserts when count >= AFULL_THRESH (legal range 1..512).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_valid  input  1  producer offers i_data this cycle.
REQ-005 SHALL have port: i_ready  output  1  FIFO accepts; push = i_valid & i_ready.
REQ-006 SHALL have port: i_data  input  80  write payload.
REQ-007 SHALL have port: o_valid  output  1  o_data holds head entry.
REQ-008 SHALL have port: o_ready  input  1  consumer takes head; pop = o_valid & o_ready.
REQ-009 SHALL have port: o_data  output  80  head payload, stable while o_valid & !o_ready.
REQ-010 SHALL have port: count  output  10  total entries held (RAM + output stage), 0..512.
REQ-011 SHALL have port: almost_full  output  1  registered, count >= AFULL_THRESH.

Function
REQ-012 SHALL store entries in one 512x80 dual-port RAM with a 1-cycle registered read (rden-gated) and an output stage of at most 2 entries; total capacity SHALL be 512.
REQ-013 SHALL assert i_ready = (count < 512), derived from registered count only, with no combinational path from o_ready.
REQ-014 SHALL on push write i_data to RAM at wr_ptr (9 bits) and increment wr_ptr, wrapping 511->0.
REQ-015 SHALL issue a RAM read at rd_ptr (9 bits, wraps 511->0) only when the RAM holds >=1 unread entry written in an earlier cycle, and (output-stage occupancy + reads in flight - pop) < 2.
REQ-016 SHALL never issue a RAM read whose address equals the same-cycle write address of an active write, since that read returns X.
REQ-017 SHALL capture RAM q one cycle after rden into the output stage; o_data SHALL always be the oldest captured entry.
REQ-018 SHALL give fall-through latency: push at edge N into empty FIFO -> read issued cycle N+1 -> o_valid=1 in cycle N+2.
REQ-019 SHALL sustain one push and one pop per cycle indefinitely once o_valid=1 (no bubbles while count >= 2).
REQ-020 SHALL update count as count + push - pop; simultaneous push and pop SHALL leave count unchanged.
REQ-021 SHALL accept push when count = 511 with simultaneous pop (count stays 511); at count = 512 SHALL deassert i_ready even if o_ready=1.
REQ-022 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-023 SHALL keep o_valid=0 and o_data don't-care (X permitted) when no entry is in the output stage.

Reset
REQ-024 SHALL while reset=1 force wr_ptr=0, rd_ptr=0, count=0, output stage empty, in-flight read cancelled, o_valid=0, i_ready=0, almost_full=0.
REQ-025 SHALL assert i_ready=1 in the first cycle after reset deasserts.
REQ-026 SHALL discard all contents on reset mid-operation; a RAM read in flight at reset SHALL NOT load the output stage. RAM contents are not cleared.

Structure
REQ-027 SHALL instantiate mcp3_ram512x080 as its only sub-module for storage.
REQ-028 SHALL define no new package; depth (512), width (80) and pointer width (9) SHALL be local constants.

Verification
REQ-029 SHALL verify: reset, push 80'h1 at cycle 0, o_ready=1 -> o_valid=1 at cycle 2 with o_data=80'h1, count 1->0 after pop.
REQ-030 SHALL verify: 512 pushes with o_ready=0 -> count=512, i_ready=0, almost_full=1 from count 496; 513th offer not accepted.
REQ-031 SHALL verify: continuous push/pop of incrementing data for 2000 cycles -> output sequence strictly incrementing, no gaps, wrap at 512 transparent.
REQ-032 SHALL verify: count=511, push+pop same cycle -> count stays 511, i_ready stays 1; then push only -> count=512, i_ready=0.
REQ-033 SHALL verify: random o_ready stalls -> o_data stable while o_valid & !o_ready; no X on o_data when o_valid=1.
REQ-034 SHALL verify: reset asserted with count=300 and read in flight -> next cycle count=0, o_valid=0; subsequent push of 80'hA5 emerges first.
